// File: rtl/rx_seq_fsm_if.sv
// Decoded-block bus into rx_seq_fsm and checked-block bus out of it.
// The master side drives decoder blocks; the slave side is the sequence checker.
interface rx_seq_fsm_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned KEEP_W = DATA_W / 8,
  parameter int unsigned CNT_W  = 16
);
  logic              lock_v_i;
  logic              valid_i;
  logic              ctrl_v_i;
  logic              idle_v_i;
  logic              start_v_i;
  logic              term_v_i;
  logic              err_v_i;
  logic              ord_v_i;
  logic [DATA_W-1:0] data_i;
  logic [KEEP_W-1:0] keep_i;

  logic              valid_o;
  logic              ctrl_v_o;
  logic              idle_v_o;
  logic              start_v_o;
  logic              term_v_o;
  logic              err_v_o;
  logic              ord_v_o;
  logic [DATA_W-1:0] data_o;
  logic [KEEP_W-1:0] keep_o;
  logic [2:0]        state_o;
  logic [CNT_W-1:0]  err_cnt_o;

  modport master (
    output lock_v_i, valid_i, ctrl_v_i, idle_v_i, start_v_i, term_v_i, err_v_i, ord_v_i,
           data_i, keep_i,
    input  valid_o, ctrl_v_o, idle_v_o, start_v_o, term_v_o, err_v_o, ord_v_o,
           data_o, keep_o, state_o, err_cnt_o
  );

  modport slave (
    input  lock_v_i, valid_i, ctrl_v_i, idle_v_i, start_v_i, term_v_i, err_v_i, ord_v_i,
           data_i, keep_i,
    output valid_o, ctrl_v_o, idle_v_o, start_v_o, term_v_o, err_v_o, ord_v_o,
           data_o, keep_o, state_o, err_cnt_o
  );
endinterface

// File: rtl/rx_seq_fsm.sv
// Receive block-sequence checker: holds one decoded block, judges it against the
// next valid block (one-block lookahead) and emits it either unchanged or as an error block.
module rx_seq_fsm #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned KEEP_W = DATA_W / 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic         clk,
  input  logic         nreset,
  rx_seq_fsm_if.slave  bus
);
  localparam logic [2:0] ST_INIT = 3'd0;
  localparam logic [2:0] ST_C    = 3'd1;
  localparam logic [2:0] ST_D    = 3'd2;
  localparam logic [2:0] ST_T    = 3'd3;
  localparam logic [2:0] ST_E    = 3'd4;

  localparam logic [2:0] BK_C = 3'd0;
  localparam logic [2:0] BK_S = 3'd1;
  localparam logic [2:0] BK_T = 3'd2;
  localparam logic [2:0] BK_D = 3'd3;
  localparam logic [2:0] BK_E = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic              ctrl;
    logic              idle;
    logic              start;
    logic              term;
    logic              err;
    logic              ord;
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
  } blk_t;

  // First matching rule wins: error, start, terminate, other control, data.
  function automatic logic [2:0] classify(input blk_t b);
    if (b.err)                return BK_E;
    else if (b.ctrl && b.start) return BK_S;
    else if (b.ctrl && b.term)  return BK_T;
    else if (b.ctrl)            return BK_C;
    else                        return BK_D;
  endfunction

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic              held;
  logic              held_nxt;
  blk_t              cur;
  blk_t              cur_nxt;
  blk_t              in_blk;
  blk_t              out_nxt;
  blk_t              out_blk;
  logic [2:0]        in_cls;
  logic [2:0]        cur_cls;
  logic              la_ok;
  logic              fire;
  logic              valid_q;
  logic [CNT_W-1:0]  err_cnt;
  logic [DATA_W-1:0] err_data;

  assign in_blk = {bus.ctrl_v_i, bus.idle_v_i, bus.start_v_i, bus.term_v_i,
                   bus.err_v_i, bus.ord_v_i, bus.data_i, bus.keep_i};

  // Error payload: every byte 8'hFE, built bitwise so any DATA_W is legal.
  always_comb begin
    err_data = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      err_data[i] = (i % 8) != 0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= ST_INIT;
    else         state <= state_nxt;
  end

  // Next state, pipeline update and output payload selection.
  always_comb begin
    state_nxt = state;
    held_nxt  = held;
    cur_nxt   = cur;
    fire      = 1'b0;
    in_cls    = classify(in_blk);
    cur_cls   = classify(cur);
    la_ok     = (in_cls == BK_C) || (in_cls == BK_S);

    if (!bus.lock_v_i) begin
      state_nxt = ST_INIT;
      held_nxt  = 1'b0;
    end else if (bus.valid_i) begin
      held_nxt = 1'b1;
      cur_nxt  = in_blk;
      fire     = held;
      if (held) begin
        case (state)
          ST_D: begin
            if (cur_cls == BK_D)                 state_nxt = ST_D;
            else if ((cur_cls == BK_T) && la_ok) state_nxt = ST_T;
            else                                 state_nxt = ST_E;
          end
          ST_E: begin
            if (cur_cls == BK_C)                 state_nxt = ST_C;
            else if (cur_cls == BK_D)            state_nxt = ST_D;
            else if ((cur_cls == BK_T) && la_ok) state_nxt = ST_T;
            else                                 state_nxt = ST_E;
          end
          default: begin
            if (cur_cls == BK_C)      state_nxt = ST_C;
            else if (cur_cls == BK_S) state_nxt = ST_D;
            else                      state_nxt = ST_E;
          end
        endcase
      end
    end

    out_nxt     = cur;
    out_nxt.err = 1'b0;
    if (state_nxt == ST_E) begin
      out_nxt      = '0;
      out_nxt.ctrl = 1'b1;
      out_nxt.err  = 1'b1;
      out_nxt.data = err_data;
    end
  end

  // Pipeline holding register and registered outputs; payload holds between beats.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      held    <= 1'b0;
      cur     <= '0;
      valid_q <= 1'b0;
      out_blk <= '0;
      err_cnt <= '0;
    end else begin
      held    <= held_nxt;
      cur     <= cur_nxt;
      valid_q <= fire;
      if (fire) begin
        out_blk <= out_nxt;
        if ((state_nxt == ST_E) && (err_cnt != CNT_MAX)) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.valid_o   = valid_q;
  assign bus.ctrl_v_o  = out_blk.ctrl;
  assign bus.idle_v_o  = out_blk.idle;
  assign bus.start_v_o = out_blk.start;
  assign bus.term_v_o  = out_blk.term;
  assign bus.err_v_o   = out_blk.err;
  assign bus.ord_v_o   = out_blk.ord;
  assign bus.data_o    = out_blk.data;
  assign bus.keep_o    = out_blk.keep;
  assign bus.state_o   = state;
  assign bus.err_cnt_o = err_cnt;
endmodule

// File: tb/tb_rx_seq_fsm.sv
// Scoreboard bench for rx_seq_fsm: a block-level reference model predicts each output beat;
// a monitor compares on every cycle. A second instance with a 4-bit counter checks saturation.
module tb_rx_seq_fsm;
  localparam int unsigned DW  = 64;
  localparam int unsigned KW  = 8;
  localparam int unsigned CW  = 16;
  localparam int unsigned CWS = 4;

  typedef struct packed {
    logic          ctrl;
    logic          idle;
    logic          start;
    logic          term;
    logic          err;
    logic          ord;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
  } blk_t;

  typedef struct { blk_t b; int cyc; } exp_t;
  typedef struct { int st; int cnt; int cnt_s; } snap_t;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  rx_seq_fsm_if #(.DATA_W(DW), .KEEP_W(KW), .CNT_W(CW))  bus();
  rx_seq_fsm_if #(.DATA_W(DW), .KEEP_W(KW), .CNT_W(CWS)) bus_s();

  rx_seq_fsm #(.DATA_W(DW), .KEEP_W(KW), .CNT_W(CW))  dut   (.clk(clk), .nreset(nreset), .bus(bus.slave));
  rx_seq_fsm #(.DATA_W(DW), .KEEP_W(KW), .CNT_W(CWS)) dut_s (.clk(clk), .nreset(nreset), .bus(bus_s.slave));

  assign bus_s.lock_v_i  = bus.lock_v_i;
  assign bus_s.valid_i   = bus.valid_i;
  assign bus_s.ctrl_v_i  = bus.ctrl_v_i;
  assign bus_s.idle_v_i  = bus.idle_v_i;
  assign bus_s.start_v_i = bus.start_v_i;
  assign bus_s.term_v_i  = bus.term_v_i;
  assign bus_s.err_v_i   = bus.err_v_i;
  assign bus_s.ord_v_i   = bus.ord_v_i;
  assign bus_s.data_i    = bus.data_i;
  assign bus_s.keep_i    = bus.keep_i;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Block kinds straight from the classification rules.
  function automatic byte kind(input blk_t b);
    if (b.err)                  return "E";
    if (b.ctrl && b.start)      return "S";
    if (b.ctrl && b.term)       return "T";
    if (b.ctrl)                 return "C";
    return "D";
  endfunction

  // Transition table: state numbers INIT=0 C=1 D=2 T=3 E=4.
  function automatic int next_st(input int st, input byte c, input byte n);
    bit t_ok;
    t_ok = (c == "T") && (n == "C" || n == "S");
    if (st == 2) return (c == "D") ? 2 : t_ok ? 3 : 4;
    if (st == 4) return (c == "C") ? 1 : (c == "D") ? 2 : t_ok ? 3 : 4;
    return (c == "C") ? 1 : (c == "S") ? 2 : 4;
  endfunction

  function automatic blk_t mk(input byte k);
    blk_t b;
    b      = '0;
    b.data = {$urandom, $urandom};
    b.keep = KW'($urandom);
    case (k)
      "C": begin b.ctrl = 1'b1; if ($urandom_range(0, 1) == 1) b.idle = 1'b1; else b.ord = 1'b1; end
      "S": begin b.ctrl = 1'b1; b.start = 1'b1; end
      "T": begin b.ctrl = 1'b1; b.term = 1'b1; end
      "E": begin b.err = 1'b1; b.ctrl = 1'($urandom); end
      default: ;
    endcase
    return b;
  endfunction

  function automatic blk_t rand_blk();
    int   r;
    blk_t b;
    r = $urandom_range(0, 99);
    if (r < 10) begin
      b = mk("D");
      {b.ctrl, b.idle, b.start, b.term, b.err, b.ord} = 6'($urandom);
    end
    else if (r < 30) b = mk("C");
    else if (r < 45) b = mk("S");
    else if (r < 60) b = mk("T");
    else if (r < 93) b = mk("D");
    else             b = mk("E");
    return b;
  endfunction

  // Reference model state
  bit        have_pend = 1'b0;
  blk_t      pend;
  int        mstate = 0;
  int        mcnt = 0;
  int        mcnt_s = 0;
  exp_t      q[$];
  snap_t     snap[int];

  task automatic drive(input bit lk, input bit vl, input blk_t b);
    blk_t eb;
    int   ns;
    @(posedge clk); #1;
    bus.lock_v_i = lk;  bus.valid_i = vl;
    bus.ctrl_v_i = b.ctrl; bus.idle_v_i = b.idle; bus.start_v_i = b.start;
    bus.term_v_i = b.term; bus.err_v_i = b.err;   bus.ord_v_i = b.ord;
    bus.data_i   = b.data; bus.keep_i = b.keep;
    if (!lk) begin
      have_pend = 1'b0;
      mstate    = 0;
    end else if (vl) begin
      if (have_pend) begin
        ns     = next_st(mstate, kind(pend), kind(b));
        mstate = ns;
        if (ns == 4) begin
          eb      = '0;
          eb.ctrl = 1'b1;
          eb.err  = 1'b1;
          eb.data = {8{8'hFE}};
          if (mcnt < 65535) mcnt++;
          if (mcnt_s < 15)  mcnt_s++;
        end else begin
          eb     = pend;
          eb.err = 1'b0;
        end
        q.push_back('{b: eb, cyc: cyc + 1});
      end
      pend      = b;
      have_pend = 1'b1;
    end
    snap[cyc + 1] = '{st: mstate, cnt: mcnt, cnt_s: mcnt_s};
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) drive(1'b1, 1'b1, mk(s[i]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, mk("D"));
  endtask

  task automatic drop_lock();
    drive(1'b0, 1'($urandom), rand_blk());
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, 128'({bus.valid_o, bus.ctrl_v_o, bus.idle_v_o, bus.start_v_o, bus.term_v_o,
                    bus.err_v_o, bus.ord_v_o, bus.data_o, bus.keep_o, bus.state_o,
                    bus.err_cnt_o, bus_s.err_cnt_o, bus_s.state_o}), 128'(0));
  endtask

  task automatic do_reset();
    idle(1);
    @(negedge clk); #1;
    nreset    = 1'b0;
    have_pend = 1'b0;
    mstate    = 0;
    mcnt      = 0;
    mcnt_s    = 0;
    snap.delete();
    #1;
    chk_reset_outputs("reset_outputs_mid");
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
  endtask

  // Monitor: valid_o must match predicted beats; payload must equal the latest beat.
  blk_t  last = '0;
  bit    exp_now;
  exp_t  e;
  snap_t s;
  always @(negedge clk) begin
    if (!nreset) last = '0;
    exp_now = (q.size() > 0) && (q[0].cyc == cyc);
    chk("valid_o", 128'(bus.valid_o), 128'(exp_now));
    chk("sat_valid_o", 128'(bus_s.valid_o), 128'(exp_now));
    if (exp_now) begin
      e    = q.pop_front();
      last = e.b;
    end
    chk("payload", 128'({bus.ctrl_v_o, bus.idle_v_o, bus.start_v_o, bus.term_v_o, bus.err_v_o,
                         bus.ord_v_o, bus.data_o, bus.keep_o}), 128'(last));
    chk("sat_payload", 128'({bus_s.ctrl_v_o, bus_s.idle_v_o, bus_s.start_v_o, bus_s.term_v_o,
                             bus_s.err_v_o, bus_s.ord_v_o, bus_s.data_o, bus_s.keep_o}), 128'(last));
    if (snap.exists(cyc)) begin
      s = snap[cyc];
      snap.delete(cyc);
      chk("state_o", 128'(bus.state_o), 128'(s.st));
      chk("err_cnt_o", 128'(bus.err_cnt_o), 128'(s.cnt));
      chk("sat_err_cnt_o", 128'(bus_s.err_cnt_o), 128'(s.cnt_s));
    end
  end

  initial begin
    bus.lock_v_i = 1'b0; bus.valid_i = 1'b0; bus.ctrl_v_i = 1'b0; bus.idle_v_i = 1'b0;
    bus.start_v_i = 1'b0; bus.term_v_i = 1'b0; bus.err_v_i = 1'b0; bus.ord_v_i = 1'b0;
    bus.data_i = '0; bus.keep_i = '0;
    #3;
    chk_reset_outputs("reset_outputs_initial");
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;

    // Clean packet: C,C,S,D,D,T,C
    drive(1'b1, 1'b0, mk("D"));
    send("CCSDDTC");
    idle(1);
    @(negedge clk); #1;
    chk("clean_pkt_err_cnt", 128'(bus.err_cnt_o), 128'(0));

    // Data straight out of INIT is an error block
    drop_lock();
    send("DC");
    idle(1);
    @(negedge clk); #1;
    chk("init_data_err_cnt", 128'(bus.err_cnt_o), 128'(1));
    chk("init_data_state", 128'(bus.state_o), 128'(4));
    chk("init_data_payload", 128'({bus.data_o, bus.keep_o}), 128'({64'hFEFEFEFEFEFEFEFE, 8'h00}));

    // Terminate followed by data fails the lookahead
    drop_lock();
    send("SDTD");
    idle(1);

    // Lock loss mid-packet, then refill
    drop_lock();
    send("SD");
    drop_lock();
    send("CC");
    idle(1);

    // Gap in valid_i mid-packet
    drop_lock();
    send("SD");
    idle(3);
    send("DTC");
    idle(1);

    // Long error run saturates the narrow counter
    drop_lock();
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, mk("E"));
    idle(1);
    @(negedge clk); #1;
    chk("sat_cnt_15", 128'(bus_s.err_cnt_o), 128'(15));

    // Reset while a block is held
    send("SD");
    do_reset();
    send("CCS");
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      drive(1'($urandom_range(0, 39) != 0), 1'($urandom_range(0, 4) != 0), rand_blk());
    end
    idle(2);
    @(negedge clk); #1;
    chk("scoreboard_drained", 128'(q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rx_seq_fsm.md
RX_SEQ_FSM -- requirements
Module: rx_seq_fsm

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning block payload width in bits.
REQ-002 SHALL have parameter KEEP_W, default DATA_W/8, meaning byte-enable width.
REQ-003 SHALL have parameter CNT_W, default 16, meaning error counter width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port nreset, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port lock_v_i, input, 1, block lock asserted and no high BER.
REQ-007 SHALL have port valid_i, input, 1, decoded block present this cycle.
REQ-008 SHALL have ports ctrl_v_i, idle_v_i, start_v_i, term_v_i, err_v_i and ord_v_i, each input, 1, decoder block flags; err_v_i flags a bad sync header or block type.
REQ-009 SHALL have ports data_i (input, DATA_W) and keep_i (input, KEEP_W), decoded payload and byte enables.
REQ-010 SHALL have ports valid_o, ctrl_v_o, idle_v_o, start_v_o, term_v_o, err_v_o and ord_v_o, each output, 1, checked block flags.
REQ-011 SHALL have ports data_o (output, DATA_W) and keep_o (output, KEEP_W), checked payload.
REQ-012 SHALL have port state_o, output, 3, current state encoding: INIT=0, C=1, D=2, T=3, E=4.
REQ-013 SHALL have port err_cnt_o, output, CNT_W, count of blocks output as error.

Function
REQ-014 SHALL classify each valid_i block; the first matching rule applies:
- E: err_v_i.
- S: ctrl_v_i & start_v_i.
- T: ctrl_v_i & term_v_i.
- C: ctrl_v_i, covering idle and ordered set.
- D: !ctrl_v_i.
REQ-015 SHALL hold one block in a pipeline register and decide on it only when the next valid block arrives, so a T decision can look ahead one block.
REQ-016 SHALL give a latency of exactly one valid_i beat, with valid_o pulsing in the cycle after the valid_i that completes the lookahead pair.
REQ-017 SHALL drive valid_o=0 in any cycle with valid_i=0; all other outputs hold their last value.
REQ-018 SHALL apply these state transitions for the held block (cur) with lookahead block (nxt):
- INIT: C->C; S->D; otherwise->E.
- C: C->C; S->D; otherwise->E.
- D: D->D; T with nxt in {C,S}->T; otherwise->E.
- T: C->C; S->D; otherwise->E.
- E: C->C; D->D; T with nxt in {C,S}->T; otherwise stays E.
REQ-019 SHALL, when the new state is C, D or T, pass cur flags, data and keep through unchanged with err_v_o=0.
REQ-020 SHALL, when the new state is E, output ctrl_v_o=1, err_v_o=1, data_o all bytes 8'hFE, keep_o=0, with idle, start, term and ord all 0.
REQ-021 SHALL increment err_cnt_o by 1 per block output in E, saturating at all-ones with no wrap.
REQ-022 SHALL, on lock_v_i=0 in any cycle, go to INIT, empty the pipeline register and drive valid_o=0 that cycle.
REQ-023 SHALL discard any block with valid_i=1 while lock_v_i=0.
REQ-024 SHALL, on lock regain, treat the first valid block as pipeline fill only, with no output.
REQ-025 SHALL give lock_v_i=0 priority over valid_i in the same cycle.
REQ-026 SHALL leave err_cnt_o unchanged on lock loss; only reset clears it.

Reset
REQ-027 SHALL, on nreset=0, immediately set state INIT, the pipeline empty and all outputs 0, including err_cnt_o=0 and state_o=0.
REQ-028 SHALL, when nreset asserts mid-packet, discard the held block, with no output generated for it.
REQ-029 SHALL, after nreset deasserts, need one fill block before the first valid_o.

Verification
REQ-030 SHALL cover: lock, then C,C,S,D,D,T,C -> valid_o for blocks 1..6, states 1,1,2,2,2,3, err_cnt_o=0.
REQ-031 SHALL cover: INIT, then D,C -> first output is an error block (data_o=64'hFEFEFEFEFEFEFEFE, keep_o=0, state_o=4), err_cnt_o=1.
REQ-032 SHALL cover: S,D,T,D -> T output as error (state_o=4), since nxt is D.
REQ-033 SHALL cover: S,D with lock_v_i dropped for 1 cycle, then C,C -> no output for the dropped cycle or the first C, state_o=0 then 1.
REQ-034 SHALL cover: CNT_W=4 with 20 consecutive E blocks -> err_cnt_o saturates at 15.
REQ-035 SHALL cover: valid_i low for 3 cycles mid-packet (S,D,gap,D,T,C) -> valid_o=0 during the gap, with no state change or error.
